// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding
// and a constant-evaluable ceil(log2) used to size the counters.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period timing for the serial transmitter: div_cnt paces one bit,
// bit_cnt tracks which bit of the word is on the line.
module bit_period_counter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick,
  output logic last
);

  localparam int unsigned DIV_W = clog2(DIV + 1);
  localparam int unsigned BIT_W = clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign tick = (div_cnt_q == DIV_LAST);
  assign last = (bit_cnt_q == BIT_LAST);

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (enable) begin
      if (tick) begin
        div_cnt_d = '0;
        // Terminal bit is followed by a clear, so bit_cnt never exceeds WIDTH.
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: shifts a WIDTH-bit word out LSB first,
// one bit per DIV cycles, with a per-bit capture strobe and a done pulse.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  output logic             out,
  output logic             load,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             tick, last;
  logic             out_q, out_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  bit_period_counter #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q == SHIFT),
    .clear  (state_q != SHIFT),
    .tick   (tick),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (tick && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the current state and then registered, so the
  // pins trail the FSM by one cycle and have no path from the inputs.
  always_comb begin
    out_d  = 1'b0;
    load_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      SHIFT: begin
        out_d  = sr_q[0];
        load_d = tick;
        busy_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (state_q == IDLE && start) begin
      sr_d = in;
    end else if (state_q == SHIFT && tick) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // NOTE: the shift register is a data path, but it is reset too so an aborted frame leaves no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      out_q  <= 1'b0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      out_q  <= out_d;
      load_q <= load_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign out  = out_q;
  assign load = load_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: a DIV=2 and a DIV=1 instance, each feeding
// a 16-cell shift-in register, with bit and word scoreboards.
module tb_serial_word_tx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_w = '0;
  logic         start0 = 1'b0, start1 = 1'b0;
  logic         out0, load0, busy0, done0;
  logic         out1, load1, busy1, done1;
  logic [W-1:0] chain0, chain1;

  bit           sel = 1'b0;
  logic         obs_out, obs_load, obs_busy, obs_done;
  logic [W-1:0] obs_chain;

  int checks = 0;
  int failures = 0;

  bit           bit_q[$];
  logic [W-1:0] word_q[$];

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(W), .DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in_w), .start(start0),
    .out(out0), .load(load0), .busy(busy0), .done(done0)
  );

  serial_word_tx #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in_w), .start(start1),
    .out(out1), .load(load1), .busy(busy1), .done(done1)
  );

  // Downstream chains of DFF cells capturing out on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain0 <= '0;
    else if (load0) chain0 <= {out0, chain0[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain1 <= '0;
    else if (load1) chain1 <= {out1, chain1[W-1:1]};
  end

  assign obs_out   = sel ? out1   : out0;
  assign obs_load  = sel ? load1  : load0;
  assign obs_busy  = sel ? busy1  : busy0;
  assign obs_done  = sel ? done1  : done0;
  assign obs_chain = sel ? chain1 : chain0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic eo, input logic el,
                               input logic eb, input logic ed);
    check({tag, ".out"},  obs_out,  eo);
    check({tag, ".load"}, obs_load, el);
    check({tag, ".busy"}, obs_busy, eb);
    check({tag, ".done"}, obs_done, ed);
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // Starts a frame at the next rising edge (E0) and checks every cycle after it.
  task automatic send(input bit s, input logic [W-1:0] word, input bit hold, input bit repulse);
    int div, total, k;
    bit exp_bit;
    logic [W-1:0] exp_word;
    sel   = s;
    div   = s ? 1 : 2;
    total = W * div;
    in_w  = word;
    set_start(s, 1'b1);
    @(posedge clk);
    for (int i = 0; i < W; i++) bit_q.push_back(word[i]);
    word_q.push_back(word);
    #1;
    in_w = ~word;
    if (!hold) set_start(s, 1'b0);
    @(negedge clk);
    check_outputs($sformatf("d%0d.gap", div), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= total + 1; n++) begin
      @(negedge clk);
      if (n <= total) begin
        k = (n - 1) / div;
        check_outputs($sformatf("d%0d.n%0d", div, n), word[k],
                      ((n - 1) % div) == (div - 1), 1'b1, 1'b0);
        if (obs_load) begin
          check("sb_bit_depth", bit_q.size() > 0, 1);
          if (bit_q.size() > 0) begin
            exp_bit = bit_q.pop_front();
            check($sformatf("sb_bit.n%0d", n), obs_out, exp_bit);
          end
        end
      end else begin
        check_outputs($sformatf("d%0d.done", div), 1'b0, 1'b0, 1'b0, 1'b1);
        check("sb_word_depth", word_q.size() > 0, 1);
        if (word_q.size() > 0) begin
          exp_word = word_q.pop_front();
          check($sformatf("chain.%04h", word), obs_chain, exp_word);
        end
      end
      if (repulse && n == 4) begin
        in_w = '1;
        set_start(s, 1'b1);
      end
      if (repulse && n == 6) set_start(s, 1'b0);
    end
    if (!hold) begin
      repeat (2) begin
        @(negedge clk);
        check_outputs($sformatf("d%0d.idle", div), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;

    // Reset held: toggling start must not wake either instance.
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start0 = (i % 2) == 0;
      start1 = (i % 2) == 0;
      #2;
      check_outputs($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst.busy1", busy1, 1'b0);
      check("rst.done1", done1, 1'b0);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;

    // First start on the first edge after release.
    send(0, 16'hA5C3, 0, 0);
    send(1, 16'h0001, 0, 0);
    send(0, 16'h1234, 0, 1);

    // Start held across frames: exactly one DONE and one IDLE cycle between.
    send(0, 16'h0F0F, 1, 0);
    send(0, 16'hBEEF, 0, 0);

    send(0, 16'h0000, 0, 0);
    send(0, 16'hFFFF, 0, 0);
    send(0, 16'h8001, 0, 0);
    send(1, 16'h8001, 0, 0);
    repeat (3) begin
      r = 16'($urandom);
      send(0, r, 0, 0);
    end
    repeat (2) begin
      r = 16'($urandom);
      send(1, r, 0, 0);
    end

    // Reset during bit 5 of a DIV=2 frame.
    sel    = 1'b0;
    in_w   = 16'h5A3C;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check("mid.busy_before", obs_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_outputs("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_outputs("mid.hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    send(0, 16'h6E2B, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
